// File: rtl/bdi_pkg.sv
// Shared types for the BDI line-fetch front end: mode codes, per-mode compressed
// sizes and the fetch FSM state encoding.
package bdi_pkg;

    typedef logic [3:0] bdi_mode_t;

    localparam bdi_mode_t RPV4     = 4'b0000;
    localparam bdi_mode_t RPV8     = 4'b0001;
    localparam bdi_mode_t B8D1     = 4'b0010;
    localparam bdi_mode_t B8D2     = 4'b0011;
    localparam bdi_mode_t B8D4     = 4'b0100;
    localparam bdi_mode_t B4D1     = 4'b0101;
    localparam bdi_mode_t B4D2     = 4'b0110;
    localparam bdi_mode_t B2D1     = 4'b0111;
    localparam bdi_mode_t NO_COMPR = 4'b1111;

    localparam int unsigned LINE_WORDS = 8;

    typedef enum logic [2:0] {
        IDLE,
        META,
        CALC,
        DATA,
        OUT
    } fetch_state_t;

    // Undefined codes are treated as a raw 32-byte line.
    function automatic logic [5:0] bdi_size_bytes(input bdi_mode_t mode);
        logic [5:0] size;
        case (mode)
            RPV4:     size = 6'd4;
            RPV8:     size = 6'd8;
            B8D1:     size = 6'd12;
            B8D2:     size = 6'd16;
            B8D4:     size = 6'd24;
            B4D1:     size = 6'd12;
            B4D2:     size = 6'd20;
            B2D1:     size = 6'd18;
            NO_COMPR: size = 6'd32;
            default:  size = 6'd32;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/bdi_fetch_len.sv
// Number of 32-bit data words to fetch for the selected line of a pair.
// The MS line sits after the LS line, so selecting it pulls both.
module bdi_fetch_len
    import bdi_pkg::*;
(
    input  bdi_mode_t   mode_ls,
    input  bdi_mode_t   mode_ms,
    input  logic        select,
    output logic [3:0]  beat_count
);

    logic [5:0] size_ls;
    logic [5:0] size_ms;
    logic       raw_ls;
    logic       raw_ms;
    logic [6:0] total_bytes;
    logic [6:0] total_words;

    always_comb begin
        size_ls     = bdi_size_bytes(mode_ls);
        size_ms     = bdi_size_bytes(mode_ms);
        raw_ls      = (size_ls == 6'd32);
        raw_ms      = (size_ms == 6'd32);
        total_bytes = select ? (7'(size_ls) + 7'(size_ms)) : 7'(size_ls);
        total_words = (total_bytes + 7'd3) >> 2;

        // An uncompressed line anywhere in the span forces a full-line fetch.
        if (raw_ls || (select && raw_ms) || (total_words > 7'd8)) begin
            beat_count = 4'd8;
        end else begin
            beat_count = total_words[3:0];
        end
    end

endmodule

// File: rtl/bdi_line_fetch.sv
// Upstream stage of the BDI decompressor: reads pair metadata, fetches only the
// compressed words the selected line needs, and hands a 256-bit bundle downstream.
module bdi_line_fetch
    import bdi_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic                             req_select,
    output logic                             meta_rd_en,
    output logic [ADDR_WIDTH-1:0]            meta_rd_addr,
    input  logic [7:0]                       meta_rd_mode,
    input  logic [31:0]                      meta_rd_base_one_hot,
    output logic                             data_rd_en,
    output logic [ADDR_WIDTH-1:0]            data_rd_addr,
    input  logic [WORD_WIDTH-1:0]            data_rd_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] compressed_cachelines,
    output logic [7:0]                       compressed_mode,
    output logic [31:0]                      base_one_hot,
    output logic                             cacheline_select_signal
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  select_q, select_d;
    logic [7:0]            mode_q, mode_d;
    logic [31:0]           base_q, base_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            beat_q, beat_d;
    logic [WORD_WIDTH-1:0] words_q [LINE_WORDS];
    logic [WORD_WIDTH-1:0] words_d [LINE_WORDS];
    logic [3:0]            fetch_len;
    logic [2:0]            slot;

    bdi_fetch_len u_fetch_len (
        .mode_ls    (meta_rd_mode[3:0]),
        .mode_ms    (meta_rd_mode[7:4]),
        .select     (select_q),
        .beat_count (fetch_len)
    );

    // Beat b issues word b and captures word b-1, so DATA lasts len+1 cycles.
    assign slot = 3'(beat_q - 4'd1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        select_d   = select_q;
        mode_d     = mode_q;
        base_d     = base_q;
        len_d      = len_q;
        beat_d     = beat_q;
        words_d    = words_q;
        meta_rd_en = 1'b0;
        data_rd_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    select_d = req_select;
                    state_d  = META;
                end
            end
            META: begin
                meta_rd_en = 1'b1;
                state_d    = CALC;
            end
            CALC: begin
                mode_d  = meta_rd_mode;
                base_d  = meta_rd_base_one_hot;
                len_d   = fetch_len;
                beat_d  = 4'd0;
                for (int i = 0; i < LINE_WORDS; i++) begin
                    words_d[i] = '0;
                end
                state_d = DATA;
            end
            DATA: begin
                data_rd_en = (beat_q < len_q);
                if (beat_q != 4'd0) begin
                    words_d[slot] = data_rd_data;
                end
                if (beat_q == len_q) begin
                    state_d = OUT;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            select_q <= 1'b0;
            mode_q   <= '0;
            base_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            select_q <= select_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            words_q  <= words_d;
        end
    end

    // Ready is masked by reset so every output reads 0 while reset is held.
    assign req_ready               = rst_n && (state_q == IDLE);
    assign out_valid               = (state_q == OUT);
    assign meta_rd_addr            = addr_q;
    assign data_rd_addr            = addr_q + ADDR_WIDTH'(beat_q);
    assign compressed_mode         = mode_q;
    assign base_one_hot            = base_q;
    assign cacheline_select_signal = select_q;

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_pack
        assign compressed_cachelines[k*WORD_WIDTH +: WORD_WIDTH] = words_q[k];
    end

endmodule
